tdm_serial_rx8: RTL and testbench

- Receive end of the 8-channel transmission link. The transmit end serialises iData[7:0] one channel per slot, with the slot selected by a 3-bit channel index.
- This block watches a single idle-high serial line and detects a start slot. It samples 8 channel slots mid-bit, LSB (channel 0) first, then checks a stop slot.
- On a good stop slot it presents the reassembled byte on a parallel bus with a one-cycle valid strobe.
- It sits directly after the link wire and feeds byte-wide consumers (display, register file).

---
 rtl/tdm_serial_rx8.sv | 124 ++++++++++++
 tb/tb_tdm_serial_rx8.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tdm_serial_rx8.sv
// Receive end of the 8-channel TDM serial link. It detects a start slot on an idle-high
// line, samples 8 channel slots mid-bit (channel 0 first) and checks the stop slot.
module tdm_serial_rx8 #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iSer,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrameErr,
  output logic       oBusy,
  output logic [2:0] oSel
);

  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW   = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          err_q;
  logic          busy_q;
  logic [2:0]    sel_q;
  logic [7:0]    shift_d;

  // The slot being received lands in the bit named by the current channel index.
  always_comb begin
    shift_d        = shift_q;
    shift_d[sel_q] = iSer;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= 8'hFF;
      data_q  <= 8'hFF;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 3'd0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!iSer) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          // A start slot that is back to 1 at mid-slot was only a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            sel_q <= 3'd0;
            if (iSer) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            sel_q   <= sel_q + 3'd1;
            if (sel_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (iSer) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          sel_q   <= 3'd0;
        end
      endcase
    end
  end

  assign oData     = data_q;
  assign oValid    = valid_q;
  assign oFrameErr = err_q;
  assign oBusy     = busy_q;
  assign oSel      = sel_q;

endmodule

// File: tb/tb_tdm_serial_rx8.sv
// Bench for tdm_serial_rx8: directed and randomized frames checked cycle by cycle
// against a slot-timing model built from frame position arithmetic.
module tb_tdm_serial_rx8;

  localparam int BC         = 4;
  localparam int HALF       = BC / 2;
  localparam int STOP_EDGE  = HALF + 9 * BC;
  localparam int FRAME_LEN  = 10 * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic       iSer;
  logic [7:0] oData;
  logic       oValid;
  logic       oFrameErr;
  logic       oBusy;
  logic [2:0] oSel;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] expData  = 8'hFF;

  tdm_serial_rx8 #(.BIT_CYCLES(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .iSer      (iSer),
    .oData     (oData),
    .oValid    (oValid),
    .oFrameErr (oFrameErr),
    .oBusy     (oBusy),
    .oSel      (oSel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic expBusy, input logic [2:0] expSel,
                          input logic expValid, input logic expErr);
    checkOutput({tag, ".oData"},     oData,               expData);
    checkOutput({tag, ".oBusy"},     {7'd0, oBusy},       {7'd0, expBusy});
    checkOutput({tag, ".oSel"},      {5'd0, oSel},        {5'd0, expSel});
    checkOutput({tag, ".oValid"},    {7'd0, oValid},      {7'd0, expValid});
    checkOutput({tag, ".oFrameErr"}, {7'd0, oFrameErr},   {7'd0, expErr});
  endtask

  // Line level the transmitter would drive at frame edge e; off-sample edges may be noise.
  function automatic logic lineAt(input int e, input logic [7:0] d, input logic s, input logic noise);
    int   slot;
    logic isSample;
    logic natural;
    slot     = e / BC;
    isSample = (e == 0) || (e == HALF) ||
               ((e >= HALF + BC) && (e <= STOP_EDGE) && ((e - HALF) % BC == 0));
    if (slot == 0)      natural = 1'b0;
    else if (slot <= 8) natural = d[slot-1];
    else                natural = s;
    if (noise && !isSample) return 1'($urandom_range(0, 1));
    return natural;
  endfunction

  // Drives one frame from its detection edge (e=0) through lastEdge, checking every cycle.
  task automatic applyStimulus(input string tag, input logic [7:0] d, input logic s,
                               input logic noise, input int lastEdge);
    logic       expBusy;
    logic [2:0] expSel;
    for (int e = 0; e <= lastEdge; e++) begin
      iSer = (e == FRAME_LEN - 1) ? 1'b1 : lineAt(e, d, s, noise);
      tick();
      expBusy = (e < STOP_EDGE);
      expSel  = ((e >= HALF) && (e < HALF + 8 * BC)) ? 3'((e - HALF) / BC) : 3'd0;
      if (e == STOP_EDGE && s) expData = d;
      checkAll(tag, expBusy, expSel, (e == STOP_EDGE) && s, (e == STOP_EDGE) && !s);
    end
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      iSer = 1'b1;
      tick();
      checkAll(tag, 1'b0, 3'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    rst  = 1'b1;
    iSer = 1'b1;
    tick();
    tick();
    checkAll("reset", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idleCycles("idle0", 3);

    $display("[TB] single frame A5");
    applyStimulus("frameA5", 8'hA5, 1'b1, 1'b0, FRAME_LEN - 1);
    idleCycles("idle1", 2);

    $display("[TB] false start");
    iSer = 1'b0;
    tick();
    checkAll("false.e0", 1'b1, 3'd0, 1'b0, 1'b0);
    iSer = 1'b1;
    tick();
    checkAll("false.e1", 1'b1, 3'd0, 1'b0, 1'b0);
    tick();
    checkAll("false.e2", 1'b0, 3'd0, 1'b0, 1'b0);
    idleCycles("idle2", 2);

    $display("[TB] frame error 3C");
    applyStimulus("err3C", 8'h3C, 1'b0, 1'b0, FRAME_LEN - 1);
    idleCycles("idle3", 2);

    $display("[TB] back-to-back 01 then FE");
    applyStimulus("b2b01", 8'h01, 1'b1, 1'b0, FRAME_LEN - 1);
    applyStimulus("b2bFE", 8'hFE, 1'b1, 1'b0, FRAME_LEN - 1);
    idleCycles("idle4", 2);

    $display("[TB] randomized frames with off-sample noise");
    for (int f = 0; f < 8; f++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      applyStimulus("rand", rd, rs, 1'b1, FRAME_LEN - 1);
      idleCycles("randIdle", $urandom_range(0, 3));
    end

    $display("[TB] reset in channel 4 of 5A");
    applyStimulus("abort5A", 8'h5A, 1'b1, 1'b0, HALF + 5 * BC - 1);
    rst  = 1'b1;
    iSer = 1'b1;
    tick();
    expData = 8'hFF;
    checkAll("midReset", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idleCycles("postReset", 5);
    applyStimulus("frame77", 8'h77, 1'b1, 1'b0, FRAME_LEN - 1);
    idleCycles("idle5", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
